// File: rtl/cdc_bus_tx.sv
// cdc_bus_tx: source end of a two-phase toggle req/ack multi-bit clock-domain crossing.
// Optional ack timeout / transfer abandon is enabled with `define CDC_BUS_TX_TIMEOUT_EN.
module cdc_bus_tx #(
    parameter int WIDTH   = 8,
    parameter int STAGES  = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_req,
    input  logic             ack_in,
    output logic             busy,
    output logic             timeout
);
    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_e;

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("cdc_bus_tx: STAGES must be at least 2");
        end
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("cdc_bus_tx: TIMEOUT must be at least 1");
        end
    endgenerate

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_req_q, out_req_d;
    logic [STAGES-1:0] ack_sync_q, ack_sync_d;
    logic              ack_s;
    logic              ack_match;

    assign ack_sync_d = {ack_sync_q[STAGES-2:0], ack_in};
    assign ack_s      = ack_sync_q[STAGES-1];
    assign ack_match  = (ack_s == out_req_q);

    // Ready only when the previous toggle has been echoed back, even in IDLE,
    // so a stale ack after reset cannot complete the next transfer early.
    assign in_ready = (state_q == IDLE) && ack_match;
    assign busy     = (state_q == WAIT_ACK);
    assign out_data = out_data_q;
    assign out_req  = out_req_q;

`ifdef CDC_BUS_TX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          timeout_q, timeout_d;
    logic          expired;

    assign cnt_inc = cnt_q + 1'b1;
    assign expired = (cnt_inc == CW'(TIMEOUT));
    assign timeout = timeout_q;

    always_comb begin
        cnt_d = cnt_q;
        if (in_valid && in_ready) begin
            cnt_d = '0;
        end else if (state_q == WAIT_ACK) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_req_d  = out_req_q;
`ifdef CDC_BUS_TX_TIMEOUT_EN
        timeout_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    out_data_d = in_data;
                    out_req_d  = ~out_req_q;
                    state_d    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_match) begin
                    state_d = IDLE;
`ifdef CDC_BUS_TX_TIMEOUT_EN
                end else if (expired) begin
                    // Abandon: realign req to the synchronized ack so the toggles agree again.
                    out_req_d = ack_s;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            out_data_q <= '0;
            out_req_q  <= 1'b0;
            ack_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_req_q  <= out_req_d;
            ack_sync_q <= ack_sync_d;
        end
    end

endmodule

// File: tb/tb_cdc_bus_tx.sv
// tb_cdc_bus_tx: directed + randomized checks of cdc_bus_tx against a toggle-protocol model.
// Timeout scenarios run when CDC_BUS_TX_TIMEOUT_EN is defined.
module tb_cdc_bus_tx;
    localparam int WIDTH   = 8;
    localparam int STAGES  = 2;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_req;
    logic             ack_in = 1'b0;
    logic             busy;
    logic             timeout;

    cdc_bus_tx #(.WIDTH(WIDTH), .STAGES(STAGES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_req(out_req),
        .ack_in(ack_in), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: expected req level = parity of accepted words; expected data = last accepted word.
    logic             exp_req  = 1'b0;
    logic [WIDTH-1:0] exp_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] w, input bit keep_valid);
        in_data  = w;
        in_valid = 1'b1;
        chk("ready_pre_accept", in_ready, 1);
        tick();
        if (!keep_valid) in_valid = 1'b0;
        exp_req  = ~exp_req;
        exp_data = w;
        chk("acc_out_data", out_data, exp_data);
        chk("acc_out_req", out_req, exp_req);
        chk("acc_busy", busy, 1);
        chk("acc_in_ready", in_ready, 0);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("hold_busy", busy, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_data", out_data, exp_data);
            chk("hold_out_req", out_req, exp_req);
            chk("hold_timeout", timeout, 0);
        end
    endtask

    // Destination echoes req; completion is seen STAGES+1 edges after the ack change.
    task automatic ack_return();
        ack_in = exp_req;
        for (int i = 1; i <= STAGES + 1; i++) begin
            tick();
            chk("ret_in_ready", in_ready, (i == STAGES + 1) ? 1 : 0);
            chk("ret_busy", busy, (i == STAGES + 1) ? 0 : 1);
            chk("ret_out_data", out_data, exp_data);
            chk("ret_timeout", timeout, 0);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        int               gap, dly;

        // Reset state
        tick();
        tick();
        chk("rst_out_data", out_data, 0);
        chk("rst_out_req", out_req, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_out_req", out_req, 0);
        chk("idle_out_data", out_data, 0);
        chk("idle_timeout", timeout, 0);

        // Single transfer, ack echoed after 3 cycles
        send(8'hA5, 1'b0);
        hold(3);
        ack_return();

        // Randomized transfers; in_valid asserted while busy must be ignored
        for (int k = 0; k < 7; k++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                tick();
                chk("gap_in_ready", in_ready, 1);
                chk("gap_busy", busy, 0);
            end
            w = WIDTH'($urandom);
            send(w, 1'b0);
            dly = $urandom_range(0, 4);
            in_data  = ~w;
            in_valid = (dly != 0);
            hold(dly);
            in_valid = 1'b0;
            ack_return();
        end

        // Back-to-back with in_valid held high: req sequence 1,0,1
        chk("b2b_start_req", out_req, 0);
        send(8'h01, 1'b1);
        in_data = 8'h02;
        hold(1);
        ack_return();
        send(8'h02, 1'b1);
        in_data = 8'h03;
        hold(1);
        ack_return();
        send(8'h03, 1'b0);
        hold(1);
        ack_return();
        chk("b2b_end_req", out_req, 1);

        // Reset during WAIT_ACK while destination keeps ack_in=1
        send(8'h5A, 1'b0);
        hold(1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_req", out_req, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        exp_req  = 1'b0;
        exp_data = '0;
        for (int i = 0; i < STAGES; i++) tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stale_ack_in_ready", in_ready, 0);
            chk("stale_ack_busy", busy, 0);
        end
        ack_in = 1'b0;
        for (int i = 1; i <= STAGES; i++) begin
            tick();
            chk("realign_in_ready", in_ready, (i == STAGES) ? 1 : 0);
        end
        send(8'hC3, 1'b0);
        hold(2);
        ack_return();

`ifdef CDC_BUS_TX_TIMEOUT_EN
        // Never acked: abandon after TIMEOUT cycles
        send(8'h3C, 1'b0);
        hold(TIMEOUT - 1);
        tick();
        exp_req = ~exp_req;
        chk("to_pulse", timeout, 1);
        chk("to_busy", busy, 0);
        chk("to_out_req", out_req, exp_req);
        chk("to_in_ready", in_ready, 1);
        chk("to_out_data", out_data, exp_data);
        tick();
        chk("to_pulse_end", timeout, 0);
        chk("to_in_ready_after", in_ready, 1);

        // Ack match lands on the TIMEOUT edge: completion wins
        send(8'h96, 1'b0);
        hold(TIMEOUT - STAGES - 1);
        ack_return();
        tick();
        chk("to_race_no_pulse", timeout, 0);
        chk("to_race_out_req", out_req, exp_req);
`else
        // No timeout: waits indefinitely
        send(8'h3C, 1'b0);
        hold(TIMEOUT + 5);
        ack_return();
        chk("no_to_out_req", out_req, exp_req);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
